// File: rtl/wb_mem_pkg.sv
// ---------------------------------------------------------------------------
// wb_mem_pkg: shared defaults and request-entry type for wb_mem_slave. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package wb_mem_pkg;

  localparam int DEPTH_WORDS_DEFAULT = 1024;
  localparam int LATENCY_DEFAULT     = 3;
  localparam int QDEPTH_DEFAULT      = 2;

  localparam int AGE_W = 4;
  localparam int CNT_W = 4;

  typedef struct packed {
    logic             we;
    logic [3:0]       be;
    logic [29:0]      index;
    logic [31:0]      data;
    logic [AGE_W-1:0] age;
    logic             err;
  } req_entry_t;

endpackage

`default_nettype wire

// File: rtl/wb_mem_req_fifo.sv
// ---------------------------------------------------------------------------
// wb_mem_req_fifo: in-order request queue whose entries age every cycle. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module wb_mem_req_fifo
  import wb_mem_pkg::*;
#(
  parameter int QDEPTH = QDEPTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  req_entry_t       push_entry,
  input  logic             pop,
  input  logic             flush,
  output req_entry_t       head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  req_entry_t    slots [QDEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    return (ptr == PW'(QDEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < QDEPTH; i++) slots[i] <= '0;
    end else begin
      // Every slot ages each cycle; the newly pushed slot starts at one.
      for (int i = 0; i < QDEPTH; i++) begin
        if (push && !flush && (PW'(i) == wr_ptr)) slots[i] <= push_entry;
        else if (slots[i].age != '1)              slots[i].age <= slots[i].age + 1'b1;
      end
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= next_ptr(wr_ptr);
        if (pop)  rd_ptr <= next_ptr(rd_ptr);
        if (push && !pop)      count <= count + 1'b1;
        else if (pop && !push) count <= count - 1'b1;
      end
    end
  end

  assign head  = slots[rd_ptr];
  assign full  = (count == CNT_W'(QDEPTH));
  assign empty = (count == '0);

endmodule

`default_nettype wire

// File: rtl/wb_mem_slave.sv
// ---------------------------------------------------------------------------
// wb_mem_slave: pipelined Wishbone memory slave with fixed response latency;
// defining WB_MEM_ERR_EN adds err_out for out-of-range addresses. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module wb_mem_slave
  import wb_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEFAULT,
  parameter int LATENCY     = LATENCY_DEFAULT,
  parameter int QDEPTH      = QDEPTH_DEFAULT
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        cyc_in,
  input  logic        stb_in,
  input  logic        we_in,
  input  logic [3:0]  be_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        ack_out,
`ifdef WB_MEM_ERR_EN
  output logic        err_out,
`endif
  output logic        stall_out
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]      mem [DEPTH_WORDS];
  req_entry_t       new_entry;
  req_entry_t       head;
  logic             accept;
  logic             due;
  logic             addr_err;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] count;
  logic [AW-1:0]    head_idx;

`ifdef WB_MEM_ERR_EN
  assign addr_err = (addr_in[31:2] >= 30'(DEPTH_WORDS));
`else
  assign addr_err = 1'b0;
`endif

  always_comb begin
    new_entry       = '0;
    new_entry.we    = we_in;
    new_entry.be    = be_in;
    new_entry.index = addr_in[31:2];
    new_entry.data  = data_in;
    new_entry.age   = AGE_W'(1);
    new_entry.err   = addr_err;
  end

  assign stall_out = !sys_rst && (count == CNT_W'(QDEPTH));
  assign accept    = cyc_in && stb_in && !stall_out;
  // The head is the oldest entry, so it is the only one that can be due.
  assign due       = !sys_rst && cyc_in && !empty && (head.age == AGE_W'(LATENCY));
  assign head_idx  = head.index[AW-1:0];

  wb_mem_req_fifo #(
    .QDEPTH(QDEPTH)
  ) u_req_fifo (
    .clk       (sys_clk),
    .rst       (sys_rst),
    .push      (accept),
    .push_entry(new_entry),
    .pop       (due),
    .flush     (!cyc_in),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  always_ff @(posedge sys_clk) begin
    if (due && head.we && !head.err) begin
      for (int b = 0; b < 4; b++) begin
        if (head.be[b]) mem[head_idx][8*b +: 8] <= head.data[8*b +: 8];
      end
    end
  end

  assign ack_out  = due && !head.err;
  assign data_out = (due && !head.we && !head.err) ? mem[head_idx] : '0;
`ifdef WB_MEM_ERR_EN
  assign err_out  = due && head.err;
`endif

  logic unused_bits;
  assign unused_bits = ^{addr_in[1:0], head.index, full};

endmodule

`default_nettype wire

// File: tb/tb_wb_mem_slave.sv
// ---------------------------------------------------------------------------
// tb_wb_mem_slave: directed and randomized checks of wb_mem_slave. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_wb_mem_slave;

  localparam int LAT = 3;
  localparam int QD  = 2;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  be = 4'h0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] data_out;
  logic        ack_out;
  logic        stall_out;
  logic        err_w;

  int tests_run = 0;
  int fails = 0;

  always #5 sys_clk = ~sys_clk;

`ifdef WB_MEM_ERR_EN
  logic err_out;
  assign err_w = err_out;
`else
  assign err_w = 1'b0;
`endif

  wb_mem_slave #(.DEPTH_WORDS(1024), .LATENCY(LAT), .QDEPTH(QD)) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .cyc_in   (cyc),
    .stb_in   (stb),
    .we_in    (we),
    .be_in    (be),
    .addr_in  (addr),
    .data_in  (wdata),
    .data_out (data_out),
    .ack_out  (ack_out),
`ifdef WB_MEM_ERR_EN
    .err_out  (err_out),
`endif
    .stall_out(stall_out)
  );

  // Single request, starting and ending just after a rising edge.
  task automatic issue(input logic w, input logic [3:0] b, input logic [31:0] a,
                       input logic [31:0] d, output int lat, output logic [31:0] rd,
                       output logic was_err);
    lat = -1; rd = '0; was_err = 1'b0;
    cyc = 1'b1; stb = 1'b1; we = w; be = b; addr = a; wdata = d;
    for (int k = 0; k < 12; k++) begin
      @(negedge sys_clk);
      if (lat < 0 && (ack_out || err_w)) begin
        lat = k; rd = data_out; was_err = err_w;
      end
      @(posedge sys_clk); #1;
      stb = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge sys_clk);
    #1;
    tests_run++; if (ack_out !== 1'b0) begin fails++; $display("FAIL reset_ack: got %b want 0", ack_out); end
    tests_run++; if (stall_out !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b want 0", stall_out); end
    tests_run++; if (data_out !== 32'h0) begin fails++; $display("FAIL reset_data: got %h want 0", data_out); end
    sys_rst = 1'b0; cyc = 1'b1;
    @(posedge sys_clk); #1;
  endtask

  task automatic test_basic();
    int lat; logic [31:0] rd; logic e;
    issue(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, lat, rd, e);
    tests_run++; if (lat !== LAT) begin fails++; $display("FAIL write_latency: got %0d want %0d", lat, LAT); end
    tests_run++; if (rd !== 32'h0) begin fails++; $display("FAIL write_ack_data: got %h want 0", rd); end
    issue(1'b0, 4'hF, 32'h10, 32'h0, lat, rd, e);
    tests_run++; if (lat !== LAT) begin fails++; $display("FAIL read_latency: got %0d want %0d", lat, LAT); end
    tests_run++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL read_data: got %h want deadbeef", rd); end
  endtask

  task automatic test_byte_enable();
    int lat; logic [31:0] rd; logic e;
    issue(1'b1, 4'b0001, 32'h10, 32'h000000AA, lat, rd, e);
    issue(1'b0, 4'hF, 32'h13, 32'h0, lat, rd, e);
    tests_run++; if (rd !== 32'hDEADBEAA) begin fails++; $display("FAIL be_low_byte: got %h want deadbeaa", rd); end
    issue(1'b1, 4'b1010, 32'h10, 32'h11223344, lat, rd, e);
    issue(1'b0, 4'hF, 32'h10, 32'h0, lat, rd, e);
    tests_run++; if (rd !== 32'h11AD33AA) begin fails++; $display("FAIL be_mixed: got %h want 11ad33aa", rd); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] rd; logic e; int n;
    int ack_cyc[$]; logic [31:0] got[$]; logic st[4];
    int exp_cyc[4] = '{3, 4, 7, 8};
    for (int i = 0; i < 4; i++) issue(1'b1, 4'hF, 32'h20 + 32'(4*i), 32'hA0000000 + 32'(i), lat, rd, e);
    n = 0;
    for (int k = 0; k < 14; k++) begin
      cyc = 1'b1; stb = (n < 4); we = 1'b0; be = 4'hF; addr = 32'h20 + 32'(4*n);
      @(negedge sys_clk);
      if (k < 4) st[k] = stall_out;
      if (ack_out) begin ack_cyc.push_back(k); got.push_back(data_out); end
      if (stb && !stall_out) n++;
      @(posedge sys_clk); #1;
    end
    stb = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (st[k] !== (k >= 2)) begin fails++; $display("FAIL b2b_stall[%0d]: got %b want %b", k, st[k], k >= 2); end
    end
    tests_run++; if (ack_cyc.size() != 4) begin fails++; $display("FAIL b2b_ack_count: got %0d want 4", ack_cyc.size()); end
    for (int i = 0; i < 4 && i < ack_cyc.size(); i++) begin
      tests_run++;
      if (ack_cyc[i] != exp_cyc[i] || got[i] !== 32'hA0000000 + 32'(i)) begin
        fails++; $display("FAIL b2b_ack[%0d]: got cycle %0d data %h want cycle %0d data %h",
                          i, ack_cyc[i], got[i], exp_cyc[i], 32'hA0000000 + 32'(i));
      end
    end
  endtask

  task automatic test_flush();
    logic any_ack; logic st2, st3;
    any_ack = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc = (k != 2); stb = (k <= 2); we = 1'b0; be = 4'hF; addr = 32'h20 + 32'(4*k);
      @(negedge sys_clk);
      if (k == 2) st2 = stall_out;
      if (k == 3) st3 = stall_out;
      if (ack_out || err_w) any_ack = 1'b1;
      @(posedge sys_clk); #1;
    end
    stb = 1'b0; cyc = 1'b1;
    tests_run++; if (st2 !== 1'b1) begin fails++; $display("FAIL flush_stall_before: got %b want 1", st2); end
    tests_run++; if (st3 !== 1'b0) begin fails++; $display("FAIL flush_stall_after: got %b want 0", st3); end
    tests_run++; if (any_ack !== 1'b0) begin fails++; $display("FAIL flush_no_ack: got %b want 0", any_ack); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] rd; logic e;
    issue(1'b1, 4'hF, 32'h30, 32'h12345678, lat, rd, e);
    issue(1'b1, 4'hF, 32'h34, 32'h9ABCDEF0, lat, rd, e);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h30; wdata = 32'h0;
    @(posedge sys_clk); #1; addr = 32'h34;
    @(posedge sys_clk); #1; stb = 1'b0;
    @(posedge sys_clk); #1;
    @(negedge sys_clk);
    tests_run++; if (ack_out !== 1'b1 || stall_out !== 1'b1) begin
      fails++; $display("FAIL rstmid_pre: got ack %b stall %b want 1 1", ack_out, stall_out); end
    #1 sys_rst = 1'b1;
    #1;
    tests_run++; if (ack_out !== 1'b0 || stall_out !== 1'b0 || data_out !== 32'h0) begin
      fails++; $display("FAIL rstmid_outputs: got ack %b stall %b data %h want 0 0 0", ack_out, stall_out, data_out); end
    @(posedge sys_clk); #2 sys_rst = 1'b0;
    @(posedge sys_clk); #1;
    issue(1'b0, 4'hF, 32'h30, 32'h0, lat, rd, e);
    tests_run++; if (rd !== 32'h12345678) begin fails++; $display("FAIL rstmid_read30: got %h want 12345678", rd); end
    issue(1'b0, 4'hF, 32'h34, 32'h0, lat, rd, e);
    tests_run++; if (rd !== 32'h9ABCDEF0) begin fails++; $display("FAIL rstmid_read34: got %h want 9abcdef0", rd); end
  endtask

  task automatic test_range();
    int lat; logic [31:0] rd; logic e;
    issue(1'b1, 4'hF, 32'h0, 32'hCAFEF00D, lat, rd, e);
`ifdef WB_MEM_ERR_EN
    issue(1'b0, 4'hF, 32'h1000, 32'h0, lat, rd, e);
    tests_run++; if (lat !== LAT || e !== 1'b1 || rd !== 32'h0) begin
      fails++; $display("FAIL range_err_read: got lat %0d err %b data %h want 3 1 0", lat, e, rd); end
    issue(1'b1, 4'hF, 32'h1000, 32'h0, lat, rd, e);
    tests_run++; if (e !== 1'b1) begin fails++; $display("FAIL range_err_write: got err %b want 1", e); end
    issue(1'b0, 4'hF, 32'h0, 32'h0, lat, rd, e);
    tests_run++; if (rd !== 32'hCAFEF00D || e !== 1'b0) begin
      fails++; $display("FAIL range_no_write: got %h err %b want cafef00d 0", rd, e); end
`else
    issue(1'b0, 4'hF, 32'h1000, 32'h0, lat, rd, e);
    tests_run++; if (lat !== LAT || rd !== 32'hCAFEF00D) begin
      fails++; $display("FAIL range_wrap_read: got lat %0d data %h want 3 cafef00d", lat, rd); end
    issue(1'b1, 4'hF, 32'h1004, 32'h11111111, lat, rd, e);
    issue(1'b0, 4'hF, 32'h4, 32'h0, lat, rd, e);
    tests_run++; if (rd !== 32'h11111111) begin fails++; $display("FAIL range_wrap_write: got %h want 11111111", rd); end
`endif
  endtask

  // Reference model: a list of pending requests stamped with their acceptance cycle.
  typedef struct {
    logic        w;
    logic [3:0]  b;
    int          idx;
    logic [31:0] d;
    logic        err;
    int          acc;
  } mreq_t;

  task automatic test_random();
    int lat; logic [31:0] rd; logic e;
    logic [31:0] mmem [16];
    mreq_t pend[$];
    mreq_t r;
    logic c, s, due, x_ack, x_err, x_stall;
    logic [31:0] x_data, a;
    int widx;
    for (int i = 0; i < 16; i++) begin
      mmem[i] = $urandom;
      issue(1'b1, 4'hF, 32'h100 + 32'(4*i), mmem[i], lat, rd, e);
    end
    for (int t = 0; t < 400; t++) begin
      c = ($urandom_range(0, 19) != 0);
      s = ($urandom_range(0, 9) < 7);
      a = {($urandom_range(0, 1) == 1) ? 20'($urandom) : 20'h0, 10'(64 + $urandom_range(0, 15)), 2'($urandom)};
      cyc = c; stb = s; we = 1'($urandom); be = 4'($urandom); addr = a; wdata = $urandom;
      @(negedge sys_clk);
      x_stall = (pend.size() == QD);
      due     = c && pend.size() > 0 && (t - pend[0].acc == LAT);
      x_ack   = due && !pend[0].err;
      x_err   = due && pend[0].err;
      x_data  = (x_ack && !pend[0].w) ? mmem[pend[0].idx] : 32'h0;
      tests_run++;
      if (ack_out !== x_ack || err_w !== x_err || data_out !== x_data || stall_out !== x_stall) begin
        fails++;
        $display("FAIL rand_cycle %0d: got ack %b err %b data %h stall %b want %b %b %h %b",
                 t, ack_out, err_w, data_out, stall_out, x_ack, x_err, x_data, x_stall);
      end
      if (due) begin
        if (pend[0].w && !pend[0].err)
          for (int b = 0; b < 4; b++)
            if (pend[0].b[b]) mmem[pend[0].idx][8*b +: 8] = pend[0].d[8*b +: 8];
        void'(pend.pop_front());
      end
      if (!c) pend.delete();
      else if (s && !x_stall) begin
        widx  = int'((a >> 2) % 1024) - 64;
        r.w   = we; r.b = be; r.idx = widx; r.d = wdata; r.acc = t;
`ifdef WB_MEM_ERR_EN
        r.err = ((a >> 2) >= 1024);
`else
        r.err = 1'b0;
`endif
        pend.push_back(r);
      end
      @(posedge sys_clk); #1;
    end
    cyc = 1'b1; stb = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_byte_enable();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_range();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wb_mem_slave.md
WB_MEM_SLAVE -- requirements
Module: wb_mem_slave

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, memory size in 32-bit words (power of two).
REQ-002 SHALL have parameter LATENCY, default 3, cycles from request acceptance to response (legal range 1..8).
REQ-003 SHALL have parameter QDEPTH, default 2, maximum outstanding accepted-but-unacknowledged requests (legal range 1..8).
REQ-004 SHALL have port sys_clk  input  1  single clock; all state on its rising edge.
REQ-005 SHALL have port sys_rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port cyc_in  input  1  bus cycle active.
REQ-007 SHALL have port stb_in  input  1  request strobe.
REQ-008 SHALL have port we_in  input  1  1 = write, 0 = read.
REQ-009 SHALL have port be_in  input  4  byte enables; bit i selects data bits 8i+7:8i.
REQ-010 SHALL have port addr_in  input  32  byte address.
REQ-011 SHALL have port data_in  input  32  write data.
REQ-012 SHALL have port data_out  output  32  read data, valid only with ack_out.
REQ-013 SHALL have port ack_out  output  1  one-cycle response pulse per accepted request.
REQ-014 SHALL have port stall_out  output  1  request not accepted this cycle.

Function
REQ-015 SHALL accept a request in a cycle where cyc_in & stb_in & !stall_out; at most one acceptance per cycle.
REQ-016 SHALL store accepted we, be, word index and data in an in-order request queue of QDEPTH entries.
REQ-017 SHALL derive word index as addr_in[log2(DEPTH_WORDS)+1:2]; addr_in[1:0] ignored.
REQ-018 SHALL assert ack_out for an accepted request exactly LATENCY cycles after its acceptance edge; responses strictly in acceptance order.
REQ-019 SHALL perform the memory write (only enabled bytes) on the ack cycle of a write; disabled bytes retain old contents.
REQ-020 SHALL drive data_out with the full addressed word on the ack cycle of a read, reflecting all earlier-acknowledged writes; data_out SHALL be 0 on a write ack and when ack_out is 0.
REQ-021 SHALL drive stall_out = 1 when the registered outstanding count equals QDEPTH, independent of an ack in the same cycle; otherwise 0.
REQ-022 SHALL keep the outstanding count unchanged when acceptance and ack coincide; increment on accept only, decrement on ack only.
REQ-023 SHALL, when cyc_in is 0, flush all pending entries at the next edge, issue no ack in any cycle where cyc_in is 0, and drop unapplied writes.
REQ-024 SHALL ignore stb_in while cyc_in is 0.

Reset
REQ-025 SHALL on sys_rst assertion immediately clear queue and count, force ack_out = 0, stall_out = 0, data_out = 0; pending requests are discarded, memory contents unchanged.
REQ-026 SHALL accept requests from the first rising edge after sys_rst deasserts.

Configuration
REQ-027 SHALL, with macro WB_MEM_ERR_EN defined, add port err_out  output  1, asserted in place of ack_out for any request with addr_in[31:2] >= DEPTH_WORDS, with no write and data_out = 0.
REQ-028 SHALL, without WB_MEM_ERR_EN, have no err_out port and wrap out-of-range addresses modulo DEPTH_WORDS.

Structure
REQ-029 SHALL take the request-entry struct typedef (we, be, index, data, age counter) and parameter defaults from shared package wb_mem_pkg.
REQ-030 SHALL implement the request queue as sub-module wb_mem_req_fifo (push, pop, flush, full, empty, count).

Verification
REQ-031 Write 0xDEADBEEF, be=4'hF, addr 0x10 at cycle 0 -> ack at cycle 3; read addr 0x10 -> ack with data_out 0xDEADBEEF.
REQ-032 Write 0x000000AA, be=4'b0001 to addr 0x10 holding 0xDEADBEEF -> subsequent read returns 0xDEADBEAA.
REQ-033 Back-to-back stb for 4 cycles, QDEPTH=2, LATENCY=3 -> stall_out high in cycles 2 and 3, acks in order, no request lost.
REQ-034 Two reads accepted, cyc_in dropped before first ack -> no ack_out ever, count 0 and stall_out 0 next cycle.
REQ-035 sys_rst asserted mid-cycle with one write outstanding -> ack_out 0 immediately, write not applied, readback unchanged.
REQ-036 With WB_MEM_ERR_EN, read addr 0x1000 (DEPTH_WORDS=1024) -> err_out at cycle 3, ack_out 0; without macro -> ack with word at index 0.
